// File: rtl/pipe_stage_chain.sv
// Purpose: parametrised pipeline-register chain with stall, flush, bubble and perf counters.
// Latency: an instruction loaded into slot 0 on one edge reaches slot k k edges later.
// Backpressure: a stall at slot k holds slots 0..k; in_ready drops and slot 0 input is dropped.
module pipe_stage_chain #(
  parameter int STAGES = 4,
  parameter int DW     = 32,
  parameter int PCW    = 32,
  parameter int CW     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [PCW-1:0]       in_pc4,
  input  logic [DW-1:0]        in_data,
  input  logic [STAGES*DW-1:0] upd_data,
  input  logic [STAGES-1:0]    stall_req,
  input  logic [STAGES-1:0]    flush_req,
  input  logic                 cnt_clr,
  output logic                 in_ready,
  output logic [STAGES-1:0]    stg_valid,
  output logic [STAGES*32-1:0] stg_instr,
  output logic [STAGES*PCW-1:0] stg_pc4,
  output logic [STAGES*DW-1:0] stg_data,
  output logic [3:0]           occupancy,
  output logic [CW-1:0]        retire_cnt,
  output logic [CW-1:0]        stall_cnt
);

  typedef struct packed {
    logic           vld;
    logic [31:0]    instr;
    logic [PCW-1:0] pc4;
    logic [DW-1:0]  dat;
  } slot_t;

  slot_t             slot_q [STAGES];
  slot_t             slot_d [STAGES];
  logic [STAGES-1:0] hold;
  logic              retire_inc;
  logic              stall_inc;
  logic              unused_upd0;

  // Slot 0 loads from in_*, so the lowest upd_data slice carries nothing.
  assign unused_upd0 = ^upd_data[DW-1:0];

  // A stall anywhere downstream freezes this slot too.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = |(stall_req >> k);
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (flush_req[0]) begin
      slot_d[0] = '0;
    end else if (!hold[0]) begin
      slot_d[0] = {in_valid, in_instr, in_pc4, in_data};
    end
    for (int k = 1; k < STAGES; k++) begin
      if (flush_req[k]) begin
        slot_d[k] = '0;
      end else if (!hold[k]) begin
        // A held upstream slot must not be copied forward, so insert a bubble.
        if (hold[k-1]) begin
          slot_d[k] = '0;
        end else begin
          slot_d[k] = {slot_q[k-1].vld, slot_q[k-1].instr, slot_q[k-1].pc4,
                       upd_data[k*DW +: DW]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign retire_inc = slot_q[STAGES-1].vld & ~hold[STAGES-1] & ~flush_req[STAGES-1];
  assign stall_inc  = hold[0];

  // Counters saturate rather than wrap; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else if (cnt_clr) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire_inc && (retire_cnt != '1)) begin
        retire_cnt <= retire_cnt + CW'(1);
      end
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    logic [3:0] occ;
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + 4'(slot_q[k].vld);
    end
    occupancy = occ;
  end

  assign in_ready = ~hold[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_out
    assign stg_valid[g]              = slot_q[g].vld;
    assign stg_instr[g*32 +: 32]     = slot_q[g].instr;
    assign stg_pc4[g*PCW +: PCW]     = slot_q[g].pc4;
    assign stg_data[g*DW +: DW]      = slot_q[g].dat;
  end

endmodule
